// File: rtl/jpc_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : jpc_stream_packer_if
// Purpose  : Output word stream of the JPEG2000 codestream packer.
//            Valid/ready handshake carrying one 32-bit word per transfer,
//            with left-aligned byte keep and an end-of-picture flag.
// Signals  : m_valid  word valid (master)
//            m_data   32-bit word, first byte in [31:24] (master)
//            m_keep   byte enables, left-aligned (master)
//            m_last   last word of the picture (master)
//            m_ready  sink accepts the word (slave)
// Revision : 1.0 - initial release
// ============================================================================
interface jpc_stream_packer_if;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_keep,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_keep,
        input  m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/jpc_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : jpc_stream_packer
// Purpose  : Packs the JPEG2000 core's codestream bytes MSB-first into
//            32-bit words, buffers them in a first-word-fall-through FIFO
//            and presents them on a valid/ready stream. The last word of
//            each picture carries m_last and a left-aligned keep. The core
//            cannot be stalled, so FIFO overflow and bytes arriving during
//            a flush are flagged with sticky error bits.
// Ports    : clk          rising-edge clock
//            rstn         asynchronous active-low reset
//            byte_in_f    codestream byte valid (no backpressure)
//            byte_in      codestream byte
//            pic_end      one-cycle pulse after the picture's last byte
//            m            output word stream (master modport)
//            pic_bytes    byte count of the last completed picture
//            pic_done     one-cycle pulse once the picture's last word is
//                         in the FIFO
//            overflow     sticky: a word was dropped on a full FIFO
//            protocol_err sticky: a byte arrived while flushing
// Revision : 1.0 - initial release
// ============================================================================
module jpc_stream_packer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire             clk,
    input  wire             rstn,
    input  wire             byte_in_f,
    input  wire [7:0]       byte_in,
    input  wire             pic_end,
    jpc_stream_packer_if.master m,
    output logic [31:0]     pic_bytes,
    output logic            pic_done,
    output logic            overflow,
    output logic            protocol_err
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_FL_PEND = 2'd1,
        ST_FL_PART = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Packer state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] pdata_q, pdata_d;
    logic        pvalid_q, pvalid_d;
    logic        pushed_any_q, pushed_any_d;
    logic [31:0] bytecnt_q, bytecnt_d;

    // Push request produced by the packer; registered once before the FIFO.
    logic        push_d;
    logic [36:0] push_entry_d;
    logic        push_q;
    logic [36:0] push_entry_q;

    logic [31:0] pic_bytes_q;
    logic        pic_done_q;
    logic        overflow_q;
    logic        protocol_err_q;

    logic [31:0] acc_ins;   // accumulator with the incoming byte in its lane
    logic [3:0]  part_keep;
    logic        err_set;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [36:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full;
    logic          fifo_pop;
    logic          fifo_wr;
    logic          fifo_drop;
    logic          out_valid;
    logic [36:0]   head;

    // Byte lane insertion: bcnt selects lane 3-bcnt, first byte lands in [31:24].
    always_comb begin
        acc_ins = acc_q;
        case (bcnt_q)
            2'd0:    acc_ins = {byte_in, acc_q[23:0]};
            2'd1:    acc_ins = {acc_q[31:24], byte_in, acc_q[15:0]};
            2'd2:    acc_ins = {acc_q[31:16], byte_in, acc_q[7:0]};
            default: acc_ins = {acc_q[31:8], byte_in};
        endcase
    end

    always_comb begin
        part_keep = 4'h0;
        case (bcnt_q)
            2'd1:    part_keep = 4'h8;
            2'd2:    part_keep = 4'hC;
            2'd3:    part_keep = 4'hE;
            default: part_keep = 4'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / push logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bcnt_d       = bcnt_q;
        pdata_d      = pdata_q;
        pvalid_d     = pvalid_q;
        pushed_any_d = pushed_any_q;
        bytecnt_d    = bytecnt_q;
        push_d       = 1'b0;
        push_entry_d = 37'd0;
        err_set      = 1'b0;

        case (state_q)
            ST_ACC: begin
                // A byte coinciding with pic_end is packed before the flush.
                if (byte_in_f) begin
                    bytecnt_d = bytecnt_q + 32'd1;
                    if (bcnt_q == 2'd3) begin
                        // The older pending word is displaced; it cannot be
                        // the last word because a newer one now exists.
                        if (pvalid_q) begin
                            push_d       = 1'b1;
                            push_entry_d = {1'b0, 4'hF, pdata_q};
                            pushed_any_d = 1'b1;
                        end
                        pdata_d  = acc_ins;
                        pvalid_d = 1'b1;
                        acc_d    = 32'd0;
                        bcnt_d   = 2'd0;
                    end else begin
                        acc_d  = acc_ins;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
                if (pic_end) begin
                    state_d = ST_FL_PEND;
                end
            end

            ST_FL_PEND: begin
                err_set = byte_in_f;
                if (pvalid_q) begin
                    push_d       = 1'b1;
                    push_entry_d = {(bcnt_q == 2'd0), 4'hF, pdata_q};
                    pvalid_d     = 1'b0;
                    pushed_any_d = 1'b1;
                end
                if (bcnt_q != 2'd0) begin
                    state_d = ST_FL_PART;
                end else begin
                    // Empty picture still produces one marker word.
                    if (!pvalid_q && !pushed_any_q) begin
                        push_d       = 1'b1;
                        push_entry_d = {1'b1, 4'h0, 32'd0};
                    end
                    state_d = ST_DONE;
                end
            end

            ST_FL_PART: begin
                err_set      = byte_in_f;
                push_d       = 1'b1;
                push_entry_d = {1'b1, part_keep, acc_q};
                acc_d        = 32'd0;
                bcnt_d       = 2'd0;
                state_d      = ST_DONE;
            end

            default: begin // ST_DONE
                err_set      = byte_in_f;
                bytecnt_d    = 32'd0;
                pushed_any_d = 1'b0;
                state_d      = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_ACC;
            acc_q          <= 32'd0;
            bcnt_q         <= 2'd0;
            pdata_q        <= 32'd0;
            pvalid_q       <= 1'b0;
            pushed_any_q   <= 1'b0;
            bytecnt_q      <= 32'd0;
            push_q         <= 1'b0;
            push_entry_q   <= 37'd0;
            pic_bytes_q    <= 32'd0;
            pic_done_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bcnt_q       <= bcnt_d;
            pdata_q      <= pdata_d;
            pvalid_q     <= pvalid_d;
            pushed_any_q <= pushed_any_d;
            bytecnt_q    <= bytecnt_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
            // pic_done lines up with the cycle the final word's FIFO write
            // becomes visible, because pushes pass through push_q first.
            pic_done_q   <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                pic_bytes_q <= bytecnt_q;
            end
            if (err_set) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign out_valid = (count_q != '0);
    assign fifo_full = (count_q == FULL_CNT);
    assign fifo_pop  = out_valid & m.m_ready;
    // A simultaneous pop frees the slot, so a push on a full FIFO survives.
    assign fifo_wr   = push_q & (~fifo_full | fifo_pop);
    assign fifo_drop = push_q & fifo_full & ~fifo_pop;
    assign head      = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wptr_q] <= push_entry_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs are forced to zero while empty so storage contents never leak.
    assign m.m_valid = out_valid;
    assign m.m_data  = out_valid ? head[31:0]  : 32'd0;
    assign m.m_keep  = out_valid ? head[35:32] : 4'h0;
    assign m.m_last  = out_valid ? head[36]    : 1'b0;

    assign pic_bytes    = pic_bytes_q;
    assign pic_done     = pic_done_q;
    assign overflow     = overflow_q;
    assign protocol_err = protocol_err_q;

endmodule
`default_nettype wire
